axi_master_if: RTL and testbench

- Single-outstanding AXI4 initiator (master) bridge. Converts a simple processor-side load/store request into single-beat AXI4 read (AR/R) or write (AW/W/B) transactions.
- Sits between the CPU memory stage / DMA front end and the AXI interconnect. It is the initiator end of the slave-side handshakes implemented by the peripheral wrappers (WDT, SRAM, ROM).

---
 rtl/axi_master_if.sv | 168 ++++++++++++++++
 tb/tb_axi_master_if.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_if.sv
// rtl/axi_master_if.sv - single-outstanding AXI4 master bridge, optional response error flag via AXI_MASTER_ERR_EN
module axi_master_if #(
  parameter logic [3:0] MASTER_ID  = 4'd0,
  parameter logic [1:0] BURST_TYPE = 2'b01
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [3:0]  ARID_M,
  output logic [31:0] ARADDR_M,
  output logic [3:0]  ARLEN_M,
  output logic [2:0]  ARSIZE_M,
  output logic [1:0]  ARBURST_M,
  output logic        ARVALID_M,
  input  logic        ARREADY_M,
  input  logic [3:0]  RID_M,
  input  logic [31:0] RDATA_M,
  input  logic [1:0]  RRESP_M,
  input  logic        RLAST_M,
  input  logic        RVALID_M,
  output logic        RREADY_M,
  output logic [3:0]  AWID_M,
  output logic [31:0] AWADDR_M,
  output logic [3:0]  AWLEN_M,
  output logic [2:0]  AWSIZE_M,
  output logic [1:0]  AWBURST_M,
  output logic        AWVALID_M,
  input  logic        AWREADY_M,
  output logic [31:0] WDATA_M,
  output logic [3:0]  WSTRB_M,
  output logic        WLAST_M,
  output logic        WVALID_M,
  input  logic        WREADY_M,
  input  logic [3:0]  BID_M,
  input  logic [1:0]  BRESP_M,
  input  logic        BVALID_M,
  output logic        BREADY_M
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR_DATA,
    WR_RESP
  } state_t;

  state_t state;

  // Single-beat, word-sized transfers only, so these fields never change.
  assign ARID_M    = MASTER_ID;
  assign ARLEN_M   = 4'd0;
  assign ARSIZE_M  = 3'b010;
  assign ARBURST_M = BURST_TYPE;
  assign AWID_M    = MASTER_ID;
  assign AWLEN_M   = 4'd0;
  assign AWSIZE_M  = 3'b010;
  assign AWBURST_M = BURST_TYPE;

`ifndef AXI_MASTER_ERR_EN
  // Response codes are not inspected in this build.
  logic unused_resp;
  assign unused_resp = ^{RRESP_M, BRESP_M};
  assign cpu_err     = 1'b0;
`endif

  // Transaction FSM; every handshake and CPU-side output is registered here.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state     <= IDLE;
      cpu_busy  <= 1'b0;
      cpu_done  <= 1'b0;
      cpu_rdata <= 32'd0;
`ifdef AXI_MASTER_ERR_EN
      cpu_err   <= 1'b0;
`endif
      ARADDR_M  <= 32'd0;
      ARVALID_M <= 1'b0;
      RREADY_M  <= 1'b0;
      AWADDR_M  <= 32'd0;
      AWVALID_M <= 1'b0;
      WDATA_M   <= 32'd0;
      WSTRB_M   <= 4'd0;
      WLAST_M   <= 1'b0;
      WVALID_M  <= 1'b0;
      BREADY_M  <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            cpu_busy <= 1'b1;
            if (cpu_we) begin
              AWADDR_M  <= cpu_addr;
              WDATA_M   <= cpu_wdata;
              WSTRB_M   <= cpu_wstrb;
              AWVALID_M <= 1'b1;
              WVALID_M  <= 1'b1;
              WLAST_M   <= 1'b1;
              state     <= WR_ADDR_DATA;
            end else begin
              ARADDR_M  <= cpu_addr;
              ARVALID_M <= 1'b1;
              state     <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (ARREADY_M) begin
            ARVALID_M <= 1'b0;
            RREADY_M  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          // Foreign-ID or non-last beats are accepted by RREADY and dropped.
          if (RVALID_M && (RID_M == MASTER_ID) && RLAST_M) begin
            cpu_rdata <= RDATA_M;
`ifdef AXI_MASTER_ERR_EN
            cpu_err   <= (RRESP_M != 2'b00);
`endif
            cpu_done  <= 1'b1;
            cpu_busy  <= 1'b0;
            RREADY_M  <= 1'b0;
            state     <= IDLE;
          end
        end
        WR_ADDR_DATA: begin
          if (AWREADY_M) begin
            AWVALID_M <= 1'b0;
          end
          if (WREADY_M) begin
            WVALID_M <= 1'b0;
            WLAST_M  <= 1'b0;
          end
          // A channel is finished once its VALID is low or handshakes now.
          if ((!AWVALID_M || AWREADY_M) && (!WVALID_M || WREADY_M)) begin
            BREADY_M <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (BVALID_M && (BID_M == MASTER_ID)) begin
`ifdef AXI_MASTER_ERR_EN
            cpu_err  <= (BRESP_M != 2'b00);
`endif
            cpu_done <= 1'b1;
            cpu_busy <= 1'b0;
            BREADY_M <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_if.sv
// tb/tb_axi_master_if.sv - directed self-checking bench for axi_master_if
module tb_axi_master_if;

  logic        ACLK;
  logic        ARESETn;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_busy;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [3:0]  ARID_M;
  logic [31:0] ARADDR_M;
  logic [3:0]  ARLEN_M;
  logic [2:0]  ARSIZE_M;
  logic [1:0]  ARBURST_M;
  logic        ARVALID_M;
  logic        ARREADY_M;
  logic [3:0]  RID_M;
  logic [31:0] RDATA_M;
  logic [1:0]  RRESP_M;
  logic        RLAST_M;
  logic        RVALID_M;
  logic        RREADY_M;
  logic [3:0]  AWID_M;
  logic [31:0] AWADDR_M;
  logic [3:0]  AWLEN_M;
  logic [2:0]  AWSIZE_M;
  logic [1:0]  AWBURST_M;
  logic        AWVALID_M;
  logic        AWREADY_M;
  logic [31:0] WDATA_M;
  logic [3:0]  WSTRB_M;
  logic        WLAST_M;
  logic        WVALID_M;
  logic        WREADY_M;
  logic [3:0]  BID_M;
  logic [1:0]  BRESP_M;
  logic        BVALID_M;
  logic        BREADY_M;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ar_hs = 0;
  int done_cnt = 0;

  axi_master_if dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
    .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
    .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
    .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
    .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
    .WREADY_M(WREADY_M),
    .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Count AR handshakes and completion pulses seen on real clock edges.
  always @(posedge ACLK) begin
    if (ARESETn && ARVALID_M && ARREADY_M) ar_hs <= ar_hs + 1;
    if (cpu_done) done_cnt <= done_cnt + 1;
  end

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset;
    ARESETn = 1'b0;
    tick();
    tick();
    total_cnt++;
    if ({ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M} !== 5'b0)
      $display("FAIL reset_handshake got=%b exp=00000", {ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M});
    else pass_cnt++;
    total_cnt++;
    if ({cpu_busy, cpu_done, cpu_err} !== 3'b0)
      $display("FAIL reset_cpu_flags got=%b exp=000", {cpu_busy, cpu_done, cpu_err});
    else pass_cnt++;
    total_cnt++;
    if ({cpu_rdata, ARADDR_M, AWADDR_M, WDATA_M} !== 128'd0)
      $display("FAIL reset_regs got=%h exp=0", {cpu_rdata, ARADDR_M, AWADDR_M, WDATA_M});
    else pass_cnt++;
    ARESETn = 1'b1;
    tick();
  endtask

  task automatic test_read_zero_wait;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_0100; ARREADY_M = 1'b1;
    tick();
    cpu_req = 1'b0;
    total_cnt++;
    if (ARVALID_M !== 1'b1 || ARADDR_M !== 32'h1001_0100 || cpu_busy !== 1'b1)
      $display("FAIL rd_ar_issue got=%b/%h/%b exp=1/10010100/1", ARVALID_M, ARADDR_M, cpu_busy);
    else pass_cnt++;
    total_cnt++;
    if ({ARID_M, ARLEN_M, ARSIZE_M, ARBURST_M} !== {4'd0, 4'd0, 3'b010, 2'b01})
      $display("FAIL rd_ar_fields got=%h exp=%h", {ARID_M, ARLEN_M, ARSIZE_M, ARBURST_M}, {4'd0, 4'd0, 3'b010, 2'b01});
    else pass_cnt++;
    tick();
    ARREADY_M = 1'b0;
    total_cnt++;
    if (ARVALID_M !== 1'b0 || RREADY_M !== 1'b1 || cpu_done !== 1'b0)
      $display("FAIL rd_rready got=%b/%b/%b exp=0/1/0", ARVALID_M, RREADY_M, cpu_done);
    else pass_cnt++;
    RVALID_M = 1'b1; RID_M = 4'd0; RLAST_M = 1'b1; RDATA_M = 32'hDEAD_BEEF; RRESP_M = 2'b00;
    tick();
    RVALID_M = 1'b0;
    total_cnt++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF || cpu_err !== 1'b0 || cpu_busy !== 1'b0 || RREADY_M !== 1'b0)
      $display("FAIL rd_done got=%b/%h/%b/%b/%b exp=1/deadbeef/0/0/0", cpu_done, cpu_rdata, cpu_err, cpu_busy, RREADY_M);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (cpu_done !== 1'b0)
      $display("FAIL rd_done_pulse got=%b exp=0", cpu_done);
    else pass_cnt++;
  endtask

  task automatic test_write_wready_delay;
    int d0;
    d0 = done_cnt;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1001_0300; cpu_wdata = 32'h0000_00FF; cpu_wstrb = 4'b0001;
    AWREADY_M = 1'b1; WREADY_M = 1'b0;
    tick();
    cpu_req = 1'b0;
    total_cnt++;
    if (AWVALID_M !== 1'b1 || WVALID_M !== 1'b1 || WLAST_M !== 1'b1 || AWADDR_M !== 32'h1001_0300 ||
        WDATA_M !== 32'h0000_00FF || WSTRB_M !== 4'b0001)
      $display("FAIL wr_issue got=%b%b%b/%h/%h/%b exp=111/10010300/000000ff/0001",
               AWVALID_M, WVALID_M, WLAST_M, AWADDR_M, WDATA_M, WSTRB_M);
    else pass_cnt++;
    tick();
    AWREADY_M = 1'b0;
    total_cnt++;
    if (AWVALID_M !== 1'b0 || WVALID_M !== 1'b1 || BREADY_M !== 1'b0)
      $display("FAIL wr_aw_drop got=%b/%b/%b exp=0/1/0", AWVALID_M, WVALID_M, BREADY_M);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++;
      if (WVALID_M !== 1'b1 || WLAST_M !== 1'b1 || BREADY_M !== 1'b0)
        $display("FAIL wr_w_hold cyc=%0d got=%b%b%b exp=110", i, WVALID_M, WLAST_M, BREADY_M);
      else pass_cnt++;
    end
    WREADY_M = 1'b1;
    tick();
    WREADY_M = 1'b0;
    total_cnt++;
    if (WVALID_M !== 1'b0 || BREADY_M !== 1'b1 || cpu_done !== 1'b0)
      $display("FAIL wr_bready got=%b/%b/%b exp=0/1/0", WVALID_M, BREADY_M, cpu_done);
    else pass_cnt++;
    BVALID_M = 1'b1; BID_M = 4'd0; BRESP_M = 2'b00;
    tick();
    BVALID_M = 1'b0;
    total_cnt++;
    if (cpu_done !== 1'b1 || BREADY_M !== 1'b0 || cpu_busy !== 1'b0 || cpu_rdata !== 32'hDEAD_BEEF)
      $display("FAIL wr_done got=%b/%b/%b/%h exp=1/0/0/deadbeef", cpu_done, BREADY_M, cpu_busy, cpu_rdata);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (done_cnt - d0 !== 1)
      $display("FAIL wr_single_done got=%0d exp=1", done_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_ar_stall;
    int a0;
    a0 = ar_hs;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2000_0040; ARREADY_M = 1'b0;
    tick();
    cpu_addr = 32'h3000_0080;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (ARVALID_M !== 1'b1 || ARADDR_M !== 32'h2000_0040)
        $display("FAIL ar_stall cyc=%0d got=%b/%h exp=1/20000040", i, ARVALID_M, ARADDR_M);
      else pass_cnt++;
      tick();
    end
    cpu_req = 1'b0; ARREADY_M = 1'b1;
    tick();
    ARREADY_M = 1'b0;
    RVALID_M = 1'b1; RID_M = 4'd0; RLAST_M = 1'b1; RDATA_M = 32'hCAFE_F00D; RRESP_M = 2'b00;
    tick();
    RVALID_M = 1'b0;
    total_cnt++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 32'hCAFE_F00D)
      $display("FAIL ar_stall_done got=%b/%h exp=1/cafef00d", cpu_done, cpu_rdata);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (ar_hs - a0 !== 1 || cpu_busy !== 1'b0)
      $display("FAIL ar_single got=%0d/%b exp=1/0", ar_hs - a0, cpu_busy);
    else pass_cnt++;
  endtask

  task automatic test_foreign_rid;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_0200; ARREADY_M = 1'b1;
    tick();
    cpu_req = 1'b0;
    tick();
    ARREADY_M = 1'b0;
    RVALID_M = 1'b1; RID_M = 4'h3; RLAST_M = 1'b1; RDATA_M = 32'hBAD0_BAD0; RRESP_M = 2'b00;
    tick();
    total_cnt++;
    if (cpu_done !== 1'b0 || RREADY_M !== 1'b1 || cpu_busy !== 1'b1 || cpu_rdata !== 32'hCAFE_F00D)
      $display("FAIL rid_foreign got=%b/%b/%b/%h exp=0/1/1/cafef00d", cpu_done, RREADY_M, cpu_busy, cpu_rdata);
    else pass_cnt++;
    RID_M = 4'd0; RDATA_M = 32'h1234_5678;
    tick();
    RVALID_M = 1'b0;
    total_cnt++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 32'h1234_5678)
      $display("FAIL rid_own got=%b/%h exp=1/12345678", cpu_done, cpu_rdata);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_in_wr_resp;
    int d0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1001_0400; cpu_wdata = 32'hA5A5_5A5A; cpu_wstrb = 4'hF;
    AWREADY_M = 1'b1; WREADY_M = 1'b1;
    tick();
    cpu_req = 1'b0;
    tick();
    AWREADY_M = 1'b0; WREADY_M = 1'b0;
    total_cnt++;
    if (BREADY_M !== 1'b1)
      $display("FAIL rst_wr_resp_entry got=%b exp=1", BREADY_M);
    else pass_cnt++;
    d0 = done_cnt;
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    total_cnt++;
    if ({ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M, cpu_busy, cpu_done} !== 7'b0)
      $display("FAIL rst_mid got=%b exp=0000000",
               {ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M, cpu_busy, cpu_done});
    else pass_cnt++;
    BVALID_M = 1'b1; BID_M = 4'd0; BRESP_M = 2'b00;
    tick();
    BVALID_M = 1'b0;
    tick();
    total_cnt++;
    if (done_cnt - d0 !== 0 || cpu_rdata !== 32'd0)
      $display("FAIL rst_no_done got=%0d/%h exp=0/00000000", done_cnt - d0, cpu_rdata);
    else pass_cnt++;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_0500; ARREADY_M = 1'b1;
    tick();
    cpu_req = 1'b0;
    tick();
    ARREADY_M = 1'b0;
    RVALID_M = 1'b1; RID_M = 4'd0; RLAST_M = 1'b1; RDATA_M = 32'h0BAD_CAFE;
    tick();
    RVALID_M = 1'b0;
    total_cnt++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 32'h0BAD_CAFE)
      $display("FAIL rst_then_read got=%b/%h exp=1/0badcafe", cpu_done, cpu_rdata);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_err;
    logic exp_err;
`ifdef AXI_MASTER_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1001_0600; cpu_wdata = 32'h1; cpu_wstrb = 4'hF;
    AWREADY_M = 1'b1; WREADY_M = 1'b1;
    tick();
    cpu_req = 1'b0;
    tick();
    AWREADY_M = 1'b0; WREADY_M = 1'b0;
    BVALID_M = 1'b1; BID_M = 4'd0; BRESP_M = 2'b10;
    tick();
    BVALID_M = 1'b0; BRESP_M = 2'b00;
    total_cnt++;
    if (cpu_done !== 1'b1 || cpu_err !== exp_err)
      $display("FAIL err_bresp got=%b/%b exp=1/%b", cpu_done, cpu_err, exp_err);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (cpu_err !== exp_err)
      $display("FAIL err_hold got=%b exp=%b", cpu_err, exp_err);
    else pass_cnt++;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_0700; ARREADY_M = 1'b1;
    tick();
    cpu_req = 1'b0;
    tick();
    ARREADY_M = 1'b0;
    RVALID_M = 1'b1; RID_M = 4'd0; RLAST_M = 1'b1; RDATA_M = 32'h5555_AAAA; RRESP_M = 2'b00;
    tick();
    RVALID_M = 1'b0;
    total_cnt++;
    if (cpu_done !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h5555_AAAA)
      $display("FAIL err_clear got=%b/%b/%h exp=1/0/5555aaaa", cpu_done, cpu_err, cpu_rdata);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    ARESETn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_wstrb = 4'd0;
    ARREADY_M = 1'b0; RID_M = 4'd0; RDATA_M = 32'd0; RRESP_M = 2'b00; RLAST_M = 1'b0; RVALID_M = 1'b0;
    AWREADY_M = 1'b0; WREADY_M = 1'b0; BID_M = 4'd0; BRESP_M = 2'b00; BVALID_M = 1'b0;
    test_reset();
    test_read_zero_wait();
    test_write_wready_delay();
    test_ar_stall();
    test_foreign_rid();
    test_reset_in_wr_resp();
    test_err();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
